// File: rtl/exc_ctrl_pkg.sv
// ============================================================================
// exc_ctrl_pkg : shared types and cause codes for the LEGv8 exception block
// Rev 1.0
// ============================================================================
`default_nettype none

package exc_ctrl_pkg;

   localparam int ESTATUS_W = 4;
   localparam int NSRC_MAX  = 14;

   localparam logic [ESTATUS_W-1:0] ESTATUS_NONE     = 4'h0;
   localparam logic [ESTATUS_W-1:0] ESTATUS_IOPC     = 4'h1;
   localparam logic [ESTATUS_W-1:0] ESTATUS_IRQ_BASE = 4'h2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } state_e;

   // A single-source encoder still needs a one-bit index.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/exc_prio_enc.sv
// ============================================================================
// exc_prio_enc : lowest-index-first priority encoder (valid + index)
// Rev 1.0
// ============================================================================
`default_nettype none

module exc_prio_enc
   import exc_ctrl_pkg::*;
#(
   parameter int N     = 4,
   parameter int IDX_W = idx_width(N)
) (
   input  logic [N-1:0]     req_i,
   output logic             valid_o,
   output logic [IDX_W-1:0] index_o
);

   // Scan downward so the lowest set index is the last one written.
   always_comb begin
      valid_o = 1'b0;
      index_o = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            valid_o = 1'b1;
            index_o = IDX_W'(i);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/exc_controller.sv
// ============================================================================
// exc_controller : exception/interrupt requester for the LEGv8 core
// (Exc/EStatus/ExcAck/ERet handshake). Optional macro: EXC_IRQ_MASK_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module exc_controller
   import exc_ctrl_pkg::*;
#(
   parameter int NSRC = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NSRC-1:0]      irq,
`ifdef EXC_IRQ_MASK_EN
   input  logic [NSRC-1:0]      irq_mask,
`endif
   input  logic                 invalid_op,
   input  logic                 ExcAck,
   input  logic                 ERet,
   output logic                 Exc,
   output logic [ESTATUS_W-1:0] EStatus,
   output logic                 in_service,
   output logic [NSRC-1:0]      pending,
   output logic                 double_fault
);

   localparam int IDX_W = idx_width(NSRC);

   state_e                 state_q, state_d;
   logic [ESTATUS_W-1:0]   estatus_q, estatus_d;
   logic [NSRC-1:0]        irq_q;
   logic [NSRC-1:0]        pending_q, pending_d;
   logic                   dfault_q, dfault_d;

   logic [NSRC-1:0]        w_edge;
   logic [NSRC-1:0]        w_eligible;
   logic [NSRC-1:0]        w_clr;
   logic                   w_sel_valid;
   logic [IDX_W-1:0]       w_sel_idx;

   assign w_edge = irq & ~irq_q;

`ifdef EXC_IRQ_MASK_EN
   assign w_eligible = pending_q & ~irq_mask;
`else
   assign w_eligible = pending_q;
`endif

   exc_prio_enc #(
      .N     (NSRC),
      .IDX_W (IDX_W)
   ) u_prio (
      .req_i   (w_eligible),
      .valid_o (w_sel_valid),
      .index_o (w_sel_idx)
   );

   always_comb begin
      state_d   = state_q;
      estatus_d = estatus_q;
      dfault_d  = dfault_q;
      w_clr     = '0;

      case (state_q)
         IDLE: begin
            if (invalid_op) begin
               state_d   = REQ;
               estatus_d = ESTATUS_IOPC;
            end else if (w_sel_valid) begin
               state_d   = REQ;
               estatus_d = ESTATUS_IRQ_BASE + ESTATUS_W'(w_sel_idx);
               for (int i = 0; i < NSRC; i++) begin
                  w_clr[i] = (w_sel_idx == IDX_W'(i));
               end
            end
         end
         REQ: begin
            if (ExcAck) begin
               state_d = SERVICE;
            end
            if (invalid_op) begin
               dfault_d = 1'b1;
            end
         end
         SERVICE: begin
            if (ERet) begin
               state_d   = IDLE;
               estatus_d = ESTATUS_NONE;
            end
            if (invalid_op) begin
               dfault_d = 1'b1;
            end
         end
         default: begin
            state_d   = IDLE;
            estatus_d = ESTATUS_NONE;
         end
      endcase

      // A fresh edge re-arms a source even if it was taken this cycle.
      pending_d = (pending_q & ~w_clr) | w_edge;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         estatus_q <= ESTATUS_NONE;
         pending_q <= '0;
         dfault_q  <= 1'b0;
         irq_q     <= irq;
      end else begin
         state_q   <= state_d;
         estatus_q <= estatus_d;
         pending_q <= pending_d;
         dfault_q  <= dfault_d;
         irq_q     <= irq;
      end
   end

   assign Exc          = (state_q == REQ);
   assign in_service   = (state_q == SERVICE);
   assign EStatus      = estatus_q;
   assign pending      = pending_q;
   assign double_fault = dfault_q;

endmodule

`default_nettype wire

// File: tb/tb_exc_controller.sv
// ============================================================================
// tb_exc_controller : table-driven, scoreboarded bench for exc_controller
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_exc_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] irq;
   logic       invalid_op, ExcAck, ERet;
   logic       Exc, in_service, double_fault;
   logic [3:0] EStatus, pending;
`ifdef EXC_IRQ_MASK_EN
   logic [3:0] irq_mask;
`endif

   always #5 clk = ~clk;

   exc_controller #(.NSRC(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .irq          (irq),
`ifdef EXC_IRQ_MASK_EN
      .irq_mask     (irq_mask),
`endif
      .invalid_op   (invalid_op),
      .ExcAck       (ExcAck),
      .ERet         (ERet),
      .Exc          (Exc),
      .EStatus      (EStatus),
      .in_service   (in_service),
      .pending      (pending),
      .double_fault (double_fault)
   );

   typedef struct {
      logic       rst;
      logic [3:0] irq;
      logic       inv, ack, eret;
      int         n;
      logic       exc;
      logic [3:0] es;
      logic       svc;
      logic [3:0] pend;
      logic       df;
   } vec_t;

   typedef struct {
      int         tag;
      logic       exc;
      logic [3:0] es;
      logic       svc;
      logic [3:0] pend;
      logic       df;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   task automatic add(input logic rst, input logic [3:0] i_irq, input logic inv,
                      input logic ack, input logic eret, input int n,
                      input logic exc, input logic [3:0] es, input logic svc,
                      input logic [3:0] pend, input logic df);
      vec_t v;
      v.rst = rst; v.irq = i_irq; v.inv = inv; v.ack = ack; v.eret = eret; v.n = n;
      v.exc = exc; v.es = es; v.svc = svc; v.pend = pend; v.df = df;
      vecs.push_back(v);
   endtask

   task automatic chk(input int tag, input string nm, input logic [3:0] act, input logic [3:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL step %0d %s: got %h, expected %h", tag, nm, act, exp);
      end
   endtask

   // Drive one cycle on the falling edge, queue the post-edge expectation,
   // then pop and compare it 1 time unit after the rising edge.
   task automatic step(input int tag, input vec_t v);
      exp_t e, got;
      @(negedge clk);
      reset = v.rst; irq = v.irq; invalid_op = v.inv; ExcAck = v.ack; ERet = v.eret;
      e.tag = tag; e.exc = v.exc; e.es = v.es; e.svc = v.svc; e.pend = v.pend; e.df = v.df;
      sb.push_back(e);
      @(posedge clk);
      #1;
      n_cmp++;
      if (sb.size() == 0) begin
         n_fail++;
         $display("FAIL step %0d scoreboard: got empty queue, expected one entry", tag);
      end else begin
         got = sb.pop_front();
         chk(got.tag, "Exc",          {3'b0, Exc},          {3'b0, got.exc});
         chk(got.tag, "EStatus",      EStatus,              got.es);
         chk(got.tag, "in_service",   {3'b0, in_service},   {3'b0, got.svc});
         chk(got.tag, "pending",      pending,              got.pend);
         chk(got.tag, "double_fault", {3'b0, double_fault}, {3'b0, got.df});
      end
   endtask

   initial begin
      int tag;
      reset = 1'b1; irq = '0; invalid_op = 1'b0; ExcAck = 1'b0; ERet = 1'b0;
`ifdef EXC_IRQ_MASK_EN
      irq_mask = '0;
`endif
      //   rst irq      inv ack ert  n   exc es    svc pend     df
      // irq[1] held through reset: no edge until it drops and rises again
      add(1, 4'b0010, 0, 0, 0,  2,  0, 4'h0, 0, 4'b0000, 0);
      add(0, 4'b0010, 0, 0, 0, 10,  0, 4'h0, 0, 4'b0000, 0);
      add(0, 4'b0000, 0, 0, 0,  1,  0, 4'h0, 0, 4'b0000, 0);
      add(0, 4'b0010, 0, 0, 0,  1,  0, 4'h0, 0, 4'b0010, 0);
      add(0, 4'b0010, 0, 0, 0,  1,  1, 4'h3, 0, 4'b0000, 0);
      add(0, 4'b0010, 0, 1, 0,  1,  0, 4'h3, 1, 4'b0000, 0);
      add(0, 4'b0010, 0, 0, 1,  1,  0, 4'h0, 0, 4'b0000, 0);
      // invalid opcode: request held until ack, then service, then ERET
      add(0, 4'b0000, 1, 0, 0,  1,  1, 4'h1, 0, 4'b0000, 0);
      add(0, 4'b0000, 0, 0, 0,  3,  1, 4'h1, 0, 4'b0000, 0);
      add(0, 4'b0000, 0, 1, 0,  1,  0, 4'h1, 1, 4'b0000, 0);
      add(0, 4'b0000, 0, 0, 1,  1,  0, 4'h0, 0, 4'b0000, 0);
      // irq[3] and irq[0] together: lowest first, back-to-back after ERET
      add(0, 4'b1001, 0, 0, 0,  1,  0, 4'h0, 0, 4'b1001, 0);
      add(0, 4'b1001, 0, 0, 0,  1,  1, 4'h2, 0, 4'b1000, 0);
      add(0, 4'b1001, 0, 1, 0,  1,  0, 4'h2, 1, 4'b1000, 0);
      add(0, 4'b1001, 0, 0, 1,  1,  0, 4'h0, 0, 4'b1000, 0);
      add(0, 4'b1001, 0, 0, 0,  1,  1, 4'h5, 0, 4'b0000, 0);
      add(0, 4'b1001, 0, 1, 0,  1,  0, 4'h5, 1, 4'b0000, 0);
      add(0, 4'b1001, 0, 0, 1,  1,  0, 4'h0, 0, 4'b0000, 0);
      // invalid_op beats irq[2] edge; invalid_op in SERVICE is a double fault
      add(0, 4'b1101, 1, 0, 0,  1,  1, 4'h1, 0, 4'b0100, 0);
      add(0, 4'b1101, 0, 1, 0,  1,  0, 4'h1, 1, 4'b0100, 0);
      add(0, 4'b1101, 1, 0, 0,  1,  0, 4'h1, 1, 4'b0100, 1);
      add(0, 4'b1101, 0, 0, 0,  1,  0, 4'h1, 1, 4'b0100, 1);
      add(0, 4'b1101, 0, 0, 1,  1,  0, 4'h0, 0, 4'b0100, 1);
      add(0, 4'b1101, 0, 0, 0,  1,  1, 4'h4, 0, 4'b0000, 1);
      // ERET alone in REQ ignored; ack+ERET in REQ is ack only
      add(0, 4'b1101, 0, 0, 1,  1,  1, 4'h4, 0, 4'b0000, 1);
      add(0, 4'b1101, 0, 1, 1,  1,  0, 4'h4, 1, 4'b0000, 1);
      add(0, 4'b1101, 0, 0, 1,  1,  0, 4'h0, 0, 4'b0000, 1);
      // reset in SERVICE with pending=0110 wipes everything
      add(0, 4'b0000, 0, 0, 0,  1,  0, 4'h0, 0, 4'b0000, 1);
      add(0, 4'b0000, 1, 0, 0,  1,  1, 4'h1, 0, 4'b0000, 1);
      add(0, 4'b0000, 0, 1, 0,  1,  0, 4'h1, 1, 4'b0000, 1);
      add(0, 4'b0110, 0, 0, 0,  1,  0, 4'h1, 1, 4'b0110, 1);
      add(1, 4'b0110, 0, 0, 0,  1,  0, 4'h0, 0, 4'b0000, 0);
      add(0, 4'b0110, 0, 0, 0,  2,  0, 4'h0, 0, 4'b0000, 0);
      // stray ack / ERET in IDLE do nothing
      add(0, 4'b0110, 0, 1, 0,  1,  0, 4'h0, 0, 4'b0000, 0);
      add(0, 4'b0110, 0, 0, 1,  1,  0, 4'h0, 0, 4'b0000, 0);

      tag = 0;
      foreach (vecs[k]) begin
         for (int r = 0; r < vecs[k].n; r++) begin
            step(tag, vecs[k]);
            tag++;
         end
      end

`ifdef EXC_IRQ_MASK_EN
      begin
         vec_t v;
         v = '{rst:0, irq:4'b0000, inv:0, ack:0, eret:0, n:1,
               exc:0, es:4'h0, svc:0, pend:4'b0000, df:0};
         irq_mask = 4'b0010;
         step(tag++, v);
         v.irq = 4'b0010; v.pend = 4'b0010;
         step(tag++, v);
         step(tag++, v);
         step(tag++, v);
         irq_mask = 4'b0000;
         v.exc = 1; v.es = 4'h3; v.pend = 4'b0000;
         step(tag++, v);
      end
`endif

      n_cmp++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard drain: got %0d leftover entries, expected 0", sb.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
